// File: rtl/palette_pkg.sv
// Shared palette definitions: default colour table, colour type and clog2 helper.
// Used by palette_decoder and palette_blink_timer.
package palette_pkg;

    localparam int unsigned PAL_COLOR_W = 12;

    typedef logic [PAL_COLOR_W-1:0] color_t;

    // Number of bits needed to index n items; 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v != 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Reset contents of the palette; entries not listed start black.
    function automatic color_t default_color(input int unsigned bank, input int unsigned idx);
        color_t c;
        c = '0;
        if (bank == 0) begin
            case (idx)
                0: c = 12'hF00;
                1: c = 12'h0F0;
                2: c = 12'h00F;
                3: c = 12'hFF0;
                default: c = '0;
            endcase
        end else if (bank == 1) begin
            case (idx)
                0: c = 12'h0FF;
                1: c = 12'hF0F;
                2: c = 12'hFF0;
                3: c = 12'h80C;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/palette_blink_timer.sv
// Frame-based blink timer: counts frame_start pulses and toggles the blink phase
// every BLINK_FRAMES frames. Instantiated by palette_decoder under PALETTE_BLINK_EN.
module palette_blink_timer
    import palette_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start_i,
    output logic phase_on_o
);

    localparam int unsigned CNT_W = (clog2(BLINK_FRAMES) < 1) ? 1 : clog2(BLINK_FRAMES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // Wrap the frame counter and flip the phase on the last frame of a half-period.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_start_i) begin
            if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_on_o = phase_q;

endmodule

// File: rtl/palette_decoder.sv
// Multi-channel palette lookup with banked register palette, frame-synchronous bank
// switching and a one-stage valid/ready output. Optional blink via PALETTE_BLINK_EN.
module palette_decoder
    import palette_pkg::*;
#(
    parameter  int unsigned NUM_CH       = 4,
    parameter  int unsigned IDX_W        = 2,
    parameter  int unsigned COLOR_W      = 12,
    parameter  int unsigned NUM_BANKS    = 2,
    parameter  int unsigned BLINK_FRAMES = 30,
    localparam int unsigned BANK_W       = (clog2(NUM_BANKS) < 1) ? 1 : clog2(NUM_BANKS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*IDX_W-1:0]   in_idx,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NUM_CH*COLOR_W-1:0] out_color,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic [BANK_W-1:0]         bank_req,
    input  logic                      frame_start,
`ifdef PALETTE_BLINK_EN
    input  logic [NUM_CH-1:0]         blink_mask,
`endif
    input  logic                      wr_en,
    input  logic [BANK_W-1:0]         wr_bank,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [COLOR_W-1:0]        wr_data,
    output logic [BANK_W-1:0]         active_bank
);

    localparam int unsigned ENTRIES    = 1 << IDX_W;
    localparam bit          BANKS_FULL = (NUM_BANKS == (1 << BANK_W));

    logic [COLOR_W-1:0]        pal_q [NUM_BANKS][ENTRIES];
    logic [BANK_W-1:0]         active_bank_q, active_bank_d;
    logic [NUM_CH*COLOR_W-1:0] out_color_q, out_color_d;
    logic                      out_valid_q, out_valid_d;
    logic [NUM_CH*COLOR_W-1:0] lut_c;
    logic                      wr_bank_ok_c;
    logic                      bank_req_ok_c;
    logic                      phase_on_c;
    logic                      accept_c;

    // Bank range checks collapse to constants when every bank code is populated.
    generate
        if (BANKS_FULL) begin : g_banks_full
            assign wr_bank_ok_c  = 1'b1;
            assign bank_req_ok_c = 1'b1;
        end else begin : g_banks_partial
            assign wr_bank_ok_c  = (wr_bank  < BANK_W'(NUM_BANKS));
            assign bank_req_ok_c = (bank_req < BANK_W'(NUM_BANKS));
        end
    endgenerate

`ifdef PALETTE_BLINK_EN
    palette_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start_i (frame_start),
        .phase_on_o    (phase_on_c)
    );
`else
    assign phase_on_c = 1'b1;
`endif

    // Palette storage; writes land at the edge so same-cycle lookups see the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    pal_q[b][i] <= COLOR_W'(default_color(b, i));
                end
            end
        end else if (wr_en && wr_bank_ok_c) begin
            pal_q[wr_bank][wr_idx] <= wr_data;
        end
    end

    // Parallel per-channel lookup in the current bank.
    always_comb begin
        lut_c = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            lut_c[k*COLOR_W +: COLOR_W] = pal_q[active_bank_q][in_idx[k*IDX_W +: IDX_W]];
`ifdef PALETTE_BLINK_EN
            if (!phase_on_c && blink_mask[k]) begin
                lut_c[k*COLOR_W +: COLOR_W] = '0;
            end
`endif
        end
    end

    assign in_ready = ~out_valid_q | out_ready;
    assign accept_c = in_valid & in_ready;

    // Output stage and frame-synchronous bank selection.
    always_comb begin
        out_color_d   = out_color_q;
        out_valid_d   = out_valid_q;
        active_bank_d = active_bank_q;
        if (accept_c) begin
            out_color_d = lut_c;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (frame_start && bank_req_ok_c) begin
            active_bank_d = bank_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_color_q   <= '0;
            out_valid_q   <= 1'b0;
            active_bank_q <= '0;
        end else begin
            out_color_q   <= out_color_d;
            out_valid_q   <= out_valid_d;
            active_bank_q <= active_bank_d;
        end
    end

    assign out_color   = out_color_q;
    assign out_valid   = out_valid_q;
    assign active_bank = active_bank_q;

    // The blink phase is only consumed when the blink feature is compiled in.
    logic unused_c;
    assign unused_c = phase_on_c;

endmodule

// File: tb/tb_palette_decoder.sv
// Scoreboard bench for palette_decoder: directed lookups, bank switching, palette
// writes, backpressure and mid-transfer reset; blink checks under PALETTE_BLINK_EN.
module tb_palette_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_idx;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] out_color;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  bank_req;
    logic        frame_start;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [1:0]  wr_idx;
    logic [11:0] wr_data;
    logic [1:0]  active_bank;
`ifdef PALETTE_BLINK_EN
    logic [3:0]  blink_mask;
`endif

    logic [47:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    palette_decoder #(
        .NUM_CH       (4),
        .IDX_W        (2),
        .COLOR_W      (12),
        .NUM_BANKS    (3),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_idx      (in_idx),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_color   (out_color),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .bank_req    (bank_req),
        .frame_start (frame_start),
`ifdef PALETTE_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .active_bank (active_bank)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every output transfer pops and compares one expected word.
    always @(negedge clk) begin
        logic [47:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %0h expected none", out_color);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard", {16'h0, out_color}, {16'h0, e});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        idle(1);
        frame_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] idx, input logic [47:0] exp);
        int waited;
        waited   = 0;
        in_idx   = idx;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int waited;
        rst_n       = 1'b0;
        in_idx      = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        bank_req    = '0;
        frame_start = 1'b0;
        wr_en       = 1'b0;
        wr_bank     = '0;
        wr_idx      = '0;
        wr_data     = '0;
`ifdef PALETTE_BLINK_EN
        blink_mask  = 4'b0000;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_out_color", {16'h0, out_color}, 64'h0);
        check("rst_active_bank", {62'h0, active_bank}, 64'h0);
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);
        rst_n = 1'b1;
        idle(1);
        check("post_rst_in_ready", {63'h0, in_ready}, 64'h1);

        // Basic lookups in bank 0
        send(8'b11_10_01_00, 48'hFF0_00F_0F0_F00);
        send(8'b00_01_10_11, 48'hF00_0F0_00F_FF0);

        // bank_req alone has no effect
        bank_req = 2'd1;
        send(8'hE4, 48'hFF0_00F_0F0_F00);
        check("bank_no_frame", {62'h0, active_bank}, 64'h0);

        // Lookup coincident with the switch uses the old bank
        frame_start = 1'b1;
        send(8'hE4, 48'hFF0_00F_0F0_F00);
        frame_start = 1'b0;
        check("bank_switch", {62'h0, active_bank}, 64'h1);
        send(8'hE4, 48'h80C_FF0_F0F_0FF);

        // Out-of-range bank request ignored, in-range bank 2 accepted
        bank_req = 2'd3;
        pulse_frame();
        check("bank_req_oob", {62'h0, active_bank}, 64'h1);
        bank_req = 2'd2;
        pulse_frame();
        check("bank_req_2", {62'h0, active_bank}, 64'h2);
        send(8'hE4, 48'h000_000_000_000);
        bank_req = 2'd0;
        pulse_frame();
        check("bank_back_0", {62'h0, active_bank}, 64'h0);

        // Write during lookup of the same entry returns the old value
        wr_en   = 1'b1;
        wr_bank = 2'd0;
        wr_idx  = 2'd2;
        wr_data = 12'hABC;
        send(8'b10_10_10_10, 48'h00F_00F_00F_00F);
        wr_en = 1'b0;
        send(8'b10_10_10_10, 48'hABC_ABC_ABC_ABC);

        // Write to an out-of-range bank ignored
        wr_en   = 1'b1;
        wr_bank = 2'd3;
        wr_data = 12'h123;
        idle(1);
        wr_en = 1'b0;
        send(8'b10_10_10_10, 48'hABC_ABC_ABC_ABC);

        // Backpressure: hold output, stall input, then drain without loss
        idle(2);
        out_ready = 1'b0;
        send(8'b11_01_00_11, 48'hFF0_0F0_F00_FF0);
        in_idx   = 8'h00;
        in_valid = 1'b1;
        exp_q.push_back(48'hF00_F00_F00_F00);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", {63'h0, in_ready}, 64'h0);
            check("bp_out_valid", {63'h0, out_valid}, 64'h1);
            check("bp_out_color", {16'h0, out_color}, {16'h0, 48'hFF0_0F0_F00_FF0});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(1);
        in_valid = 1'b0;
        idle(2);

        // Reset while an output is stalled
        bank_req = 2'd1;
        pulse_frame();
        out_ready = 1'b0;
        send(8'hE4, 48'h80C_FF0_F0F_0FF);
        idle(1);
        check("pre_rst_out_valid", {63'h0, out_valid}, 64'h1);
        rst_n = 1'b0;
        exp_q.delete();
        #2;
        check("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("mid_rst_active_bank", {62'h0, active_bank}, 64'h0);
        check("mid_rst_in_ready", {63'h0, in_ready}, 64'h1);
        bank_req = 2'd0;
        idle(1);
        rst_n = 1'b1;
        check("after_rst_in_ready", {63'h0, in_ready}, 64'h1);
        out_ready = 1'b1;
        send(8'b10_10_10_10, 48'h00F_00F_00F_00F);
        send(8'hE4, 48'hFF0_00F_0F0_F00);

`ifdef PALETTE_BLINK_EN
        // Blink: channel 0 off after two frames, back on after two more
        blink_mask = 4'b0001;
        pulse_frame();
        pulse_frame();
        send(8'hE4, 48'hFF0_00F_0F0_000);
        pulse_frame();
        pulse_frame();
        send(8'hE4, 48'hFF0_00F_0F0_F00);
`endif

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/palette_decoder.md
PALETTE_DECODER -- requirements
Module: palette_decoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of pixel channels decoded per word.
REQ-002 SHALL have parameter IDX_W, default 2, palette index width per channel; entries per bank = 2**IDX_W.
REQ-003 SHALL have parameter COLOR_W, default 12, RGB colour width (4:4:4 at default).
REQ-004 SHALL have parameter NUM_BANKS, default 2, number of palette banks; BANK_W = clog2(NUM_BANKS), minimum 1.
REQ-005 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period; used only with PALETTE_BLINK_EN.
REQ-006 One clock; reset is asynchronous and active-low: clk input 1 system clock; rst_n input 1 asynchronous active-low reset.
REQ-007 in_idx input NUM_CH*IDX_W packed indices; channel k occupies [k*IDX_W +: IDX_W]; in_valid input 1; in_ready output 1.
REQ-008 out_color output NUM_CH*COLOR_W colours; channel k occupies [k*COLOR_W +: COLOR_W]; out_valid output 1; out_ready input 1.
REQ-009 bank_req input BANK_W requested bank; frame_start input 1 single-cycle frame boundary pulse.
REQ-010 wr_en input 1; wr_bank input BANK_W; wr_idx input IDX_W; wr_data input COLOR_W: palette write port.
REQ-011 active_bank output BANK_W, the bank currently used for lookups.
REQ-012 blink_mask input NUM_CH, per-channel blink enable; present only with PALETTE_BLINK_EN.

Function
REQ-013 Palette SHALL be held in registers, NUM_BANKS x 2**IDX_W x COLOR_W, read combinationally by all channels in parallel.
REQ-014 Lookup SHALL use one output register stage with latency 1: a transfer on in_valid&in_ready updates out_color with palette[active_bank][idx_k] and asserts out_valid on the next clk edge.
REQ-015 in_ready SHALL equal !out_valid | out_ready; out_color and out_valid SHALL hold while out_valid & !out_ready.
REQ-016 out_valid SHALL clear after out_ready when there is no new input transfer in the same cycle.
REQ-017 A write SHALL update palette[wr_bank][wr_idx] at the clock edge; a lookup in the same cycle that reads the same entry SHALL return the old value.
REQ-018 Out-of-range wr_bank (>= NUM_BANKS) SHALL be ignored; out-of-range active_bank SHALL NOT be reachable.
REQ-019 active_bank SHALL load bank_req only at a cycle with frame_start=1; a bank_req change without frame_start SHALL have no effect; bank_req >= NUM_BANKS at frame_start SHALL be ignored.
REQ-020 A lookup accepted in the same cycle as a frame_start bank switch SHALL use the old active_bank.

Reset
REQ-021 On rst_n low: out_valid=0, out_color=0, active_bank=0, blink counter=0, blink phase=on.
REQ-022 Palette reset values SHALL be: bank 0 = {F00, 0F0, 00F, FF0}, bank 1 = {0FF, F0F, FF0, 80C} for entries 0..3; all other entries 0.
REQ-023 Reset asserted mid-transfer SHALL discard the pending output; in_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-024 Macro PALETTE_BLINK_EN SHALL compile in the blink feature: a frame counter counts frame_start pulses 0..BLINK_FRAMES-1 and wraps, toggling the blink phase on wrap; during the off phase a channel k with blink_mask[k]=1 is registered as 0.
REQ-025 Without PALETTE_BLINK_EN there SHALL be no blink_mask port, no counter and no phase; all channels are always decoded.

Structure
REQ-026 Package palette_pkg SHALL hold the default palette constants, a colour typedef of COLOR_W bits and a clog2 helper.
REQ-027 The blink counter and phase SHALL be one sub-module, palette_blink_timer, instantiated only under PALETTE_BLINK_EN.

Verification
REQ-028 Reset, then in_idx=8'b11_10_01_00 with in_valid=1 -> one cycle later out_color=48'hFF0_00F_0F0_F00, out_valid=1.
REQ-029 bank_req=1 without frame_start -> output unchanged; pulse frame_start, then same input -> out_color=48'h80C_FF0_F0F_0FF, active_bank=1.
REQ-030 wr_en writing bank0 idx2 = ABC in the same cycle as a lookup of idx 2 -> first result 00F, next lookup ABC; wr_bank=3 -> no change.
REQ-031 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_color stable; out_ready=1 -> next word accepted with no loss or duplication.
REQ-032 PALETTE_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001 -> after 2 frame_start pulses ch0=000 and others unchanged; after 2 more, ch0=F00.
REQ-033 rst_n pulsed low while out_valid=1 and out_ready=0 -> out_valid=0, active_bank=0, palette restored to defaults.
